pattern_index_decoder: RTL
==========================

Name: pattern_index_decoder

Overview:
- Inverse of the 4-bit → 10-output note-pattern encoder.
- Accepts a 10-bit output pattern (f0..f9) and recovers which 4-bit code(s) produce it, by scanning all 16 codes sequentially.
- Sits between the output-pattern capture logic and the music-box control FSM, which needs the code index back from a sampled pattern.
- Non-injective encoding means one pattern can match several codes; the block reports the lowest matching index and the match count.

Parameters:
- EARLY_EXIT, 0: 0 = always scan all 16 codes; 1 = stop at the first match.
- PAT_W, 10: pattern width. Fixed; other values unsupported.
- IDX_W, 4: index width. Fixed; other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  pattern offered.
- in_ready  out  1  block can accept a pattern.
- in_pat  in  10  pattern; bit k = output fk.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_found  out  1  at least one code matched.
- out_index  out  4  lowest matching code; 0 when not found.
- out_count  out  5  number of matching codes, 0..16.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_found=0, out_index=0, out_count=0. The internal pattern and scan counter are cleared.
- Reset asserted mid-SCAN or in DONE aborts the operation. There is no output pulse; the block returns to IDLE on the next edge.
- Code table (index: pattern hex) is a constant ROM inside the block:
  - 0:020, 1:260, 2:260, 3:1F3
  - 4:220, 5:0C2, 6:089, 7:31F
  - 8:260, 9:089, A:080, B:31F
  - C:0A3, D:24F, E:20F, F:11F
- States and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_pat, clear the scan counter, found, index and count, then go to SCAN. Input changes after capture have no effect.
  - SCAN: in_ready=0. One compare per edge: ROM[cnt] == captured pattern.
    - On a match: count+1. If found was 0, set found=1 and index=cnt.
    - cnt increments by 1.
    - The compare at cnt=15 is the last; go to DONE. The counter does not wrap into a 17th compare.
    - With EARLY_EXIT=1, the first match goes to DONE immediately with count=1.
  - DONE: out_valid=1. Outputs stay stable until out_ready=1. On out_valid & out_ready, go to IDLE. out_valid drops on that edge and in_ready=1 from the next cycle.
- Latency (EARLY_EXIT=0):
  - out_valid rises exactly 16 edges after the accepting edge.
  - Throughput is one pattern per 18 cycles with out_ready tied high: accept, 16 scan edges, then the DONE handshake.
- Latency (EARLY_EXIT=1): out_valid rises m+1 edges after acceptance, where m = lowest matching index; 16 edges if there is no match.
- No pipelining. A new input is never accepted while in SCAN or DONE, even if in_valid and out_ready are high together.
- out_count width is 5 bits so that 16 is representable. The ROM limits the actual maximum to 3.

Test Plan:
- Reset then walk every ROM pattern with out_ready=1 (EARLY_EXIT=0):
  - 020 → found=1, index=0, count=1.
  - 1F3 → index=3, count=1.
  - 11F → index=F, count=1.
  - Every result appears exactly 16 edges after acceptance.
- Duplicate patterns:
  - 260 → index=1, count=3.
  - 089 → index=6, count=2.
  - 31F → index=7, count=2.
- Unmatched pattern 3FF, then 000 → found=0, index=0, count=0. Neither result is reported as a match.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable and in_ready=0 while in_valid is held high.
  - Raise out_ready. Completion occurs on that edge, and in_ready=1 the following cycle.
- Drive rst_n=0 for one edge at scan step 7 of pattern 260 → out_valid stays 0, state returns to IDLE with all outputs at zero, in_ready=1. A fresh 260 then completes normally with index=1, count=3.
- EARLY_EXIT=1 build:
  - 089 → index=6, count=1, out_valid 7 edges after accept.
  - 3FF → found=0 after 16 edges.

Source files
------------

// File: rtl/pattern_index_decoder_if.sv
// -----------------------------------------------------------------------------
// pattern_index_decoder_if
// Bundles the request and response handshakes of pattern_index_decoder.
//   in_valid  : a pattern is offered
//   in_ready  : the decoder can accept a pattern
//   in_pat    : pattern, bit k = encoder output fk
//   out_valid : result is held
//   out_ready : consumer takes the result
//   out_found : at least one code matched
//   out_index : lowest matching code, 0 when nothing matched
//   out_count : number of matching codes, 0..16
// Modports: slave = decoder side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface pattern_index_decoder_if #(
    parameter int PAT_W = 10,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [PAT_W-1:0] in_pat;
    logic             out_valid;
    logic             out_ready;
    logic             out_found;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W:0]   out_count;

    modport slave (
        input  in_valid, in_pat, out_ready,
        output in_ready, out_valid, out_found, out_index, out_count
    );

    modport master (
        output in_valid, in_pat, out_ready,
        input  in_ready, out_valid, out_found, out_index, out_count
    );
endinterface

// File: rtl/pattern_index_decoder.sv
// -----------------------------------------------------------------------------
// pattern_index_decoder
// Inverse of the 4-bit -> 10-output note-pattern encoder. A captured pattern
// is compared against all 16 encoder codes, one per clock, and the block
// reports whether any code matched, the lowest matching code and how many
// codes matched (the encoding is not injective).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : pattern_index_decoder_if.slave (in/out valid-ready handshakes,
//           in_pat, out_found, out_index, out_count)
// Parameters:
//   EARLY_EXIT : 0 = scan all 16 codes, 1 = stop at the first match
//   PAT_W/IDX_W: fixed at 10/4
// -----------------------------------------------------------------------------
module pattern_index_decoder #(
    parameter bit EARLY_EXIT = 1'b0,
    parameter int PAT_W      = 10,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pattern_index_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [IDX_W-1:0] cnt_q, cnt_n;
    logic             found_q, found_n;
    logic [IDX_W-1:0] index_q, index_n;
    logic [IDX_W:0]   count_q, count_n;
    logic             match;

    // Encoder output pattern for each code.
    function automatic logic [PAT_W-1:0] code_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            4'h0:    code_rom = 10'h020;
            4'h1:    code_rom = 10'h260;
            4'h2:    code_rom = 10'h260;
            4'h3:    code_rom = 10'h1F3;
            4'h4:    code_rom = 10'h220;
            4'h5:    code_rom = 10'h0C2;
            4'h6:    code_rom = 10'h089;
            4'h7:    code_rom = 10'h31F;
            4'h8:    code_rom = 10'h260;
            4'h9:    code_rom = 10'h089;
            4'hA:    code_rom = 10'h080;
            4'hB:    code_rom = 10'h31F;
            4'hC:    code_rom = 10'h0A3;
            4'hD:    code_rom = 10'h24F;
            4'hE:    code_rom = 10'h20F;
            default: code_rom = 10'h11F;
        endcase
    endfunction

    assign match = (code_rom(cnt_q) == pat_q);

    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        cnt_n   = cnt_q;
        found_n = found_q;
        index_n = index_q;
        count_n = count_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pat_n   = bus.in_pat;
                    cnt_n   = '0;
                    found_n = 1'b0;
                    index_n = '0;
                    count_n = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    count_n = count_q + 1'b1;
                    if (!found_q) begin
                        found_n = 1'b1;
                        index_n = cnt_q;
                    end
                end
                // Code 15 is the last compare; the counter is held rather
                // than wrapped so no 17th compare can happen.
                if ((EARLY_EXIT && match) || (cnt_q == '1)) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            index_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            cnt_q   <= cnt_n;
            found_q <= found_n;
            index_q <= index_n;
            count_q <= count_n;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_found = found_q;
    assign bus.out_index = index_q;
    assign bus.out_count = count_q;

endmodule
